// File: rtl/atm_account_arbiter_pkg.sv
// atm_pkg: shared op encodings, arbiter state codes and default widths for the ATM account arbiter
package atm_pkg;
    localparam logic [1:0] OP_WITHDRAW = 2'b00;
    localparam logic [1:0] OP_DEPOSIT  = 2'b01;
    localparam logic [1:0] OP_INQUIRY  = 2'b10;
    localparam logic [1:0] OP_RSVD     = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_READ = 2'd1;
    localparam state_t ST_EXEC = 2'd2;
    localparam state_t ST_RESP = 2'd3;

    localparam int DEF_BALANCE_WIDTH = 20;
endpackage

// File: rtl/atm_account_arbiter_if.sv
// atm_account_arbiter_if: requester and balance-memory signals; ATM_ARB_TXN_LOG_EN adds txn_count/last_port
interface atm_account_arbiter_if
    import atm_pkg::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int BALANCE_WIDTH = DEF_BALANCE_WIDTH,
    parameter int ACCT_WIDTH    = 4
);
    logic [NUM_PORTS-1:0]               req;
    logic [2*NUM_PORTS-1:0]             req_op;
    logic [ACCT_WIDTH*NUM_PORTS-1:0]    req_acct;
    logic [BALANCE_WIDTH*NUM_PORTS-1:0] req_value;
    logic [NUM_PORTS-1:0]               gnt;
    logic [NUM_PORTS-1:0]               done;
    logic                               error;
    logic [BALANCE_WIDTH-1:0]           rsp_balance;
    logic                               busy;
    logic                               mem_en;
    logic                               mem_we;
    logic [ACCT_WIDTH-1:0]              mem_addr;
    logic [BALANCE_WIDTH-1:0]           mem_wdata;
    logic [BALANCE_WIDTH-1:0]           mem_rdata;
`ifdef ATM_ARB_TXN_LOG_EN
    logic [15:0]                        txn_count;
    logic [$clog2(NUM_PORTS)-1:0]       last_port;
`endif

    modport master (
        output req, req_op, req_acct, req_value, mem_rdata,
        input  gnt, done, error, rsp_balance, busy, mem_en, mem_we, mem_addr, mem_wdata
`ifdef ATM_ARB_TXN_LOG_EN
        , input txn_count, last_port
`endif
    );

    modport slave (
        input  req, req_op, req_acct, req_value, mem_rdata,
        output gnt, done, error, rsp_balance, busy, mem_en, mem_we, mem_addr, mem_wdata
`ifdef ATM_ARB_TXN_LOG_EN
        , output txn_count, last_port
`endif
    );
endinterface

// File: rtl/atm_account_arbiter_rr_pick.sv
// atm_rr_pick: combinational round-robin picker, first requester at or after rr_ptr with wrap
module atm_rr_pick #(
    parameter int NUM_PORTS = 2,
    parameter int IW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IW-1:0]        rr_ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IW-1:0]        idx,
    output logic                 any
);
    int   j;
    logic found;

    assign any = |req;

    // scan ports starting at rr_ptr and take the first one requesting
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/atm_account_arbiter.sv
// atm_account_arbiter: round-robin atomic read-modify-write access to a shared balance RAM; ATM_ARB_TXN_LOG_EN adds a completion log
module atm_account_arbiter
    import atm_pkg::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int BALANCE_WIDTH = DEF_BALANCE_WIDTH,
    parameter int ACCT_WIDTH    = 4
) (
    input logic                  clk,
    input logic                  rst,
    atm_account_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_PORTS);

    state_t                   state, state_nx;
    logic [IW-1:0]            rr_ptr, cur_idx, pick_idx;
    logic [NUM_PORTS-1:0]     pick_gnt, gnt_q;
    logic                     pick_any;
    logic [1:0]               op_q;
    logic [ACCT_WIDTH-1:0]    acct_q;
    logic [BALANCE_WIDTH-1:0] value_q, rsp_q, new_bal;
    logic [BALANCE_WIDTH:0]   sum;
    logic                     err_q, exec_err, exec_wr;

    atm_rr_pick #(.NUM_PORTS(NUM_PORTS), .IW(IW)) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .gnt    (pick_gnt),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;

    // next state: a transaction always runs IDLE -> READ -> EXEC -> RESP
    always_comb
        state_nx = (state == ST_IDLE) ? (pick_any ? ST_READ : ST_IDLE) :
                   (state == ST_READ) ? ST_EXEC :
                   (state == ST_EXEC) ? ST_RESP : ST_IDLE;

    // modify step on the read balance; errors and inquiries keep the old balance
    always_comb begin
        sum      = {1'b0, bus.mem_rdata} + {1'b0, value_q};
        new_bal  = bus.mem_rdata;
        exec_err = 1'b0;
        exec_wr  = 1'b0;
        case (op_q)
            OP_WITHDRAW: if (value_q > bus.mem_rdata) exec_err = 1'b1;
                         else begin exec_wr = 1'b1; new_bal = bus.mem_rdata - value_q; end
            OP_DEPOSIT:  if (sum[BALANCE_WIDTH]) exec_err = 1'b1;
                         else begin exec_wr = 1'b1; new_bal = sum[BALANCE_WIDTH-1:0]; end
            OP_INQUIRY:  exec_err = 1'b0;
            default:     exec_err = 1'b1;
        endcase
    end

    // outputs decoded from registered state; the memory is only touched in READ and EXEC
    always_comb begin
        bus.gnt         = gnt_q;
        bus.done        = (state == ST_RESP) ? gnt_q : '0;
        bus.error       = (state == ST_RESP) && err_q;
        bus.busy        = state != ST_IDLE;
        bus.mem_en      = (state == ST_READ) || (state == ST_EXEC && exec_wr);
        bus.mem_we      = (state == ST_EXEC) && exec_wr;
        bus.mem_addr    = acct_q;
        bus.mem_wdata   = (state == ST_EXEC && exec_wr) ? new_bal : '0;
        bus.rsp_balance = rsp_q;
    end

    // latch the winner's request, capture the result and advance the round-robin pointer
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            gnt_q   <= '0;
            cur_idx <= '0;
            rr_ptr  <= '0;
            op_q    <= '0;
            acct_q  <= '0;
            value_q <= '0;
            rsp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ST_IDLE && pick_any) begin
                gnt_q   <= pick_gnt;
                cur_idx <= pick_idx;
                op_q    <= bus.req_op[2*pick_idx +: 2];
                acct_q  <= bus.req_acct[ACCT_WIDTH*pick_idx +: ACCT_WIDTH];
                value_q <= bus.req_value[BALANCE_WIDTH*pick_idx +: BALANCE_WIDTH];
            end
            if (state == ST_EXEC) begin
                rsp_q <= new_bal;
                err_q <= exec_err;
            end
            if (state == ST_RESP) begin
                gnt_q  <= '0;
                rr_ptr <= (cur_idx == IW'(NUM_PORTS - 1)) ? '0 : cur_idx + 1'b1;
            end
        end

`ifdef ATM_ARB_TXN_LOG_EN
    // count successful transactions and remember the last completed port
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            bus.txn_count <= '0;
            bus.last_port <= '0;
        end else if (state == ST_RESP) begin
            if (!err_q) bus.txn_count <= bus.txn_count + 16'd1;
            bus.last_port <= cur_idx;
        end
`endif
endmodule

// File: tb/tb_atm_account_arbiter.sv
// tb_atm_account_arbiter: directed vectors against a behavioural balance RAM
module tb_atm_account_arbiter;
    import atm_pkg::*;

    localparam int NP = 2;
    localparam int BW = 20;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    atm_account_arbiter_if #(.NUM_PORTS(NP), .BALANCE_WIDTH(BW), .ACCT_WIDTH(AW)) bus ();

    atm_account_arbiter #(.NUM_PORTS(NP), .BALANCE_WIDTH(BW), .ACCT_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [BW-1:0] mem [16];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [BW-1:0] pl_data;

    // single-port balance RAM with one-cycle read latency and a preload port
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [BW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic set_port(input int p, input logic [1:0] op, input logic [AW-1:0] a, input logic [BW-1:0] v);
        bus.req_op[2*p +: 2]     = op;
        bus.req_acct[AW*p +: AW] = a;
        bus.req_value[BW*p +: BW] = v;
    endtask

    task automatic txn(input string tag, input int p, input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [BW-1:0] v, input logic [BW-1:0] eb, input logic ee, input logic ew);
        int w;
        w = 0;
        set_port(p, op, a, v);
        bus.req[p] = 1'b1;
        do begin @(negedge clk); w++; end while (!bus.gnt[p] && w < 20);
        check({tag, ".lat"}, w, 1);
        if (!bus.gnt[p]) begin bus.req[p] = 1'b0; return; end
        check({tag, ".rd"}, {bus.mem_en, bus.mem_we, bus.mem_addr}, {2'b10, a});
        @(negedge clk);
        check({tag, ".ex"}, {bus.mem_en, bus.mem_we}, {ew, ew});
        if (ew) check({tag, ".wd"}, bus.mem_wdata, eb);
        @(negedge clk);
        check({tag, ".done"}, bus.done, 32'(1) << p);
        check({tag, ".err"}, bus.error, ee);
        check({tag, ".bal"}, bus.rsp_balance, eb);
        bus.req[p] = 1'b0;
        @(negedge clk);
        check({tag, ".idle"}, {bus.busy, bus.gnt}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, cyc, last;
        int ord [3];
        int gap [3];
        logic [BW-1:0] bal [3];
        bus.req = '0; bus.req_op = '0; bus.req_acct = '0; bus.req_value = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        preload(4'd1, 20'd100);
        preload(4'd2, 20'd50);
        preload(4'd3, 20'd1000);
        preload(4'd5, 20'hFFFF0);
        @(negedge clk);
        check("rst.gnt", bus.gnt, 0);
        check("rst.done", bus.done, 0);
        check("rst.err_busy", {bus.error, bus.busy}, 0);
        check("rst.mem_ctl", {bus.mem_en, bus.mem_we}, 0);
        check("rst.mem_addr", bus.mem_addr, 0);
        check("rst.mem_wdata", bus.mem_wdata, 0);
        check("rst.bal", bus.rsp_balance, 0);

        // contention from reset: port0 deposits twice, port1 inquires once in between
        set_port(0, OP_DEPOSIT, 4'd1, 20'd10);
        set_port(1, OP_INQUIRY, 4'd2, 20'd0);
        bus.req = 2'b11;
        rst = 1'b1;
        n = 0; cyc = 0; last = 0;
        ord = '{-1, -1, -1}; gap = '{0, 0, 0}; bal = '{0, 0, 0};
        while (n < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.done != 0) begin
                ord[n] = bus.done[1] ? 1 : 0;
                bal[n] = bus.rsp_balance;
                gap[n] = cyc - last;
                last = cyc;
                n++;
                if (bus.done[1]) bus.req[1] = 1'b0;
                else if (n == 3) bus.req[0] = 1'b0;
            end
        end
        bus.req = '0;
        check("ct.count", n, 3);
        check("ct.ord0", ord[0], 0);
        check("ct.ord1", ord[1], 1);
        check("ct.ord2", ord[2], 0);
        check("ct.bal0", bal[0], 110);
        check("ct.bal1", bal[1], 50);
        check("ct.bal2", bal[2], 120);
        check("ct.gap0", gap[0], 3);
        check("ct.gap1", gap[1], 4);
        check("ct.gap2", gap[2], 4);
        @(negedge clk);
        check("ct.mem1", mem[1], 120);

        txn("wd",   0, OP_WITHDRAW, 4'd3, 20'd300,   20'd700,   1'b0, 1'b1);
        txn("nsf",  1, OP_WITHDRAW, 4'd3, 20'd701,   20'd700,   1'b1, 1'b0);
        txn("ovf",  0, OP_DEPOSIT,  4'd5, 20'h20,    20'hFFFF0, 1'b1, 1'b0);
        txn("dep",  0, OP_DEPOSIT,  4'd5, 20'h0F,    20'hFFFFF, 1'b0, 1'b1);
        txn("inq",  1, OP_INQUIRY,  4'd3, 20'd0,     20'd700,   1'b0, 1'b0);
        txn("rsv",  0, OP_RSVD,     4'd3, 20'd5,     20'd700,   1'b1, 1'b0);
        txn("wall", 1, OP_WITHDRAW, 4'd5, 20'hFFFFF, 20'd0,     1'b0, 1'b1);

        // reset asserted while the transaction sits in READ
        set_port(0, OP_WITHDRAW, 4'd3, 20'd100);
        bus.req[0] = 1'b1;
        @(negedge clk);
        check("rm.gnt_pre", bus.gnt, 1);
        rst = 1'b0;
        #1;
        check("rm.gnt", bus.gnt, 0);
        check("rm.busy_done", {bus.busy, bus.done}, 0);
        check("rm.mem_ctl", {bus.mem_en, bus.mem_we}, 0);
        check("rm.mem_addr", bus.mem_addr, 0);
        repeat (2) @(negedge clk);
        check("rm.mem3", mem[3], 700);
        rst = 1'b1;
        txn("rm", 0, OP_WITHDRAW, 4'd3, 20'd100, 20'd600, 1'b0, 1'b1);
        check("end.mem3", mem[3], 600);
        check("end.mem5", mem[5], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/atm_account_arbiter.md
# atm_account_arbiter

Shares one single-port account-balance memory between NUM_PORTS ATM session controllers. Each requester posts a withdraw, deposit or inquiry against an account number. The arbiter grants requesters round-robin and runs each transaction as an atomic read-modify-write. It returns the resulting balance and an error flag per transaction, and sits between the per-terminal ATM FSMs and the bank balance RAM.

## Interface
- NUM_PORTS, 2: number of ATM requesters (2..8)
- BALANCE_WIDTH, 20: balance/value width in bits
- ACCT_WIDTH, 4: account address width (2**ACCT_WIDTH accounts)
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- req  in  NUM_PORTS  per-port request, level, held until done
- req_op  in  2*NUM_PORTS  per-port op: 00 withdraw, 01 deposit, 10 inquiry, 11 reserved
- req_acct  in  ACCT_WIDTH*NUM_PORTS  per-port account number
- req_value  in  BALANCE_WIDTH*NUM_PORTS  per-port amount (ignored for inquiry)
- gnt  out  NUM_PORTS  one-hot, high from grant through done cycle
- done  out  NUM_PORTS  one-cycle completion pulse to granted port
- error  out  1  valid with done: transaction rejected
- rsp_balance  out  BALANCE_WIDTH  valid with done: account balance after transaction
- busy  out  1  transaction in progress (state != IDLE)
- mem_en, mem_we  out  1  memory enable / write enable
- mem_addr  out  ACCT_WIDTH  memory address
- mem_wdata  out  BALANCE_WIDTH  write data
- mem_rdata  in  BALANCE_WIDTH  read data, valid the cycle after mem_en && !mem_we

## Operation
- States: IDLE, READ, EXEC, RESP.
- IDLE: if any req, pick the first requesting port at or after rr_ptr (wrapping). Latch its op/acct/value, set gnt, go READ. Otherwise stay in IDLE.
- READ: mem_en=1, mem_we=0, mem_addr=latched acct. Go to EXEC.
- EXEC: mem_rdata valid. Compute:
  - withdraw: value > balance gives error; otherwise write balance - value.
  - deposit: carry out of BALANCE_WIDTH gives error (no wrap); otherwise write balance + value.
  - inquiry: no write.
  - op 11: error, no write.
  - Write means mem_en=mem_we=1 and mem_wdata=new balance.
  - Register rsp_balance: new balance on success, old balance on error or inquiry. Go RESP.
- RESP: done[granted]=1 and error valid. rr_ptr becomes granted index + 1 (mod NUM_PORTS). Clear gnt at the end of the cycle. Go IDLE.
- Requester handshake: keep req and fields stable until done. Drop req in the cycle after done. A req still high in the IDLE cycle after RESP counts as a new request.
- A req dropped mid-transaction does not abort it. The transaction completes and done is still pulsed.
- The memory is touched only in READ and EXEC. No other access interleaves, so transactions are atomic per account.
- Reset mid-transaction: all state returns to IDLE asynchronously. A write is lost if reset asserts before the EXEC edge.

## Timing
- Reset values:
  - gnt, done, error, busy, mem_en, mem_we all 0.
  - mem_addr, mem_wdata, rsp_balance 0.
  - rr_ptr 0; state IDLE.
- All outputs are registered or decoded from registered state; no combinational path from req to outputs.
- Latency: req sampled in IDLE at cycle 0. Grant in cycle 1 (READ), write in cycle 2 (EXEC), done in cycle 3 (RESP).
- Throughput: one transaction per 4 cycles under continuous requests.
- Simultaneous requests: the lowest index at or after rr_ptr wins. Losers hold req and are served in rotation. Starvation bound is (NUM_PORTS-1) transactions.

## Configuration
- ATM_ARB_TXN_LOG_EN defined:
  - adds output txn_count [15:0], incremented at each RESP without error, wrapping at 0xFFFF, reset 0.
  - adds output last_port [$clog2(NUM_PORTS)-1:0], the index of the last completed port, reset 0.
- Not defined: neither port nor counter exists; behaviour otherwise identical.

## Structure
- Shared package atm_pkg holds:
  - op encodings OP_WITHDRAW=2'b00, OP_DEPOSIT=2'b01, OP_INQUIRY=2'b10, OP_RSVD=2'b11;
  - arbiter state localparams;
  - default BALANCE_WIDTH=20.
- One sub-module, atm_rr_pick: combinational round-robin picker taking req and rr_ptr, returning one-hot grant and index. The FSM and RMW datapath stay in the top.

## Test plan
- Single withdraw: port0 withdraw 300 from acct 3 preloaded 1000 -> gnt[0] at cycle 1, mem write 700 at cycle 2, done[0] at cycle 3, rsp_balance=700, error=0.
- Insufficient funds: port1 withdraw 701 from acct 3 holding 700 -> done[1], error=1, rsp_balance=700, no mem_we observed.
- Deposit overflow: acct 5 holding 0xFFFF0, deposit 0x20 -> error=1, balance unchanged. Deposit 0x0F -> rsp_balance=0xFFFFF, error=0.
- Contention: ports 0 and 1 both request from reset -> port0 served first, then port1. Port0 re-requests immediately -> port1's transaction completes before port0's second.
- Inquiry and reserved op: inquiry on acct 3 holding 700 -> rsp_balance=700, no write. Op 11 -> error=1, no write.
- Reset mid-transaction: assert rst in READ -> all outputs 0 immediately, memory unchanged. After release, the same request completes normally.
